// File: rtl/m2v_scheduler.sv
// Round-robin scheduler that time-shares one matrix-vector systolic engine
// between NREQ requesters: grant, run the pipeline, capture, hand back the result.
module m2v_scheduler #(
    parameter int NREQ      = 4,
    parameter int DIMENSION = 16,
    parameter int WIDTH     = 8,
    parameter int SELW      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    output logic [NREQ-1:0]            gnt,
    output logic [SELW-1:0]            eng_sel,
    output logic                       eng_en,
    input  logic [DIMENSION*WIDTH-1:0] eng_mv,
    output logic [DIMENSION*WIDTH-1:0] res_data,
    output logic [SELW-1:0]            res_id,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic                       busy,
    output logic [15:0]                jobs_done
);

    localparam int unsigned RUN_LEN = 2 * DIMENSION;
    localparam int unsigned CNTW    = $clog2(RUN_LEN);
    localparam logic [CNTW-1:0] RUN_LAST = CNTW'(RUN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CAPTURE,
        RESP
    } state_t;

    state_t                     state, state_n;
    logic [SELW-1:0]            ptr, ptr_n;
    logic [CNTW-1:0]            run_cnt, run_cnt_n;
    logic [NREQ-1:0]            gnt_n;
    logic [SELW-1:0]            eng_sel_n;
    logic                       eng_en_n;
    logic [DIMENSION*WIDTH-1:0] res_data_n;
    logic [SELW-1:0]            res_id_n;
    logic                       res_valid_n;
    logic [15:0]                jobs_done_n;

    logic                       found;
    logic [SELW-1:0]            pick;
    logic [SELW-1:0]            cand;

    // Search starts at the pointer and wraps mod NREQ, which need not be a power of two.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = SELW'((32'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        run_cnt_n   = run_cnt;
        gnt_n       = gnt;
        eng_sel_n   = eng_sel;
        eng_en_n    = eng_en;
        res_data_n  = res_data;
        res_id_n    = res_id;
        res_valid_n = res_valid;
        jobs_done_n = jobs_done;

        case (state)
            IDLE: begin
                if (found) begin
                    state_n     = RUN;
                    gnt_n       = '0;
                    gnt_n[pick] = 1'b1;
                    eng_sel_n   = pick;
                    eng_en_n    = 1'b1;
                    run_cnt_n   = '0;
                    ptr_n       = SELW'((32'(pick) + 1) % NREQ);
                end
            end
            RUN: begin
                if (run_cnt == RUN_LAST) begin
                    state_n  = CAPTURE;
                    eng_en_n = 1'b0;
                end else begin
                    run_cnt_n = run_cnt + 1'b1;
                end
            end
            CAPTURE: begin
                res_data_n  = eng_mv;
                res_id_n    = eng_sel;
                res_valid_n = 1'b1;
                state_n     = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_n = 1'b0;
                    gnt_n       = '0;
                    eng_sel_n   = '0;
                    jobs_done_n = jobs_done + 16'd1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            run_cnt   <= '0;
            gnt       <= '0;
            eng_sel   <= '0;
            eng_en    <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
            jobs_done <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            run_cnt   <= run_cnt_n;
            gnt       <= gnt_n;
            eng_sel   <= eng_sel_n;
            eng_en    <= eng_en_n;
            res_data  <= res_data_n;
            res_id    <= res_id_n;
            res_valid <= res_valid_n;
            jobs_done <= jobs_done_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_m2v_scheduler.sv
// Directed bench for m2v_scheduler: grant order, run length, capture, backpressure,
// mid-run reset and jobs_done wrap, checked against hand-computed values.
module tb_m2v_scheduler;

    localparam int NREQ      = 4;
    localparam int DIMENSION = 16;
    localparam int WIDTH     = 8;
    localparam int SELW      = 2;
    localparam int DW        = DIMENSION * WIDTH;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [SELW-1:0] eng_sel;
    logic            eng_en;
    logic [DW-1:0]   eng_mv;
    logic [DW-1:0]   res_data;
    logic [SELW-1:0] res_id;
    logic            res_valid;
    logic            res_ready;
    logic            busy;
    logic [15:0]     jobs_done;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_jobs = '0;

    always #5 clk = ~clk;

    m2v_scheduler #(
        .NREQ(NREQ),
        .DIMENSION(DIMENSION),
        .WIDTH(WIDTH),
        .SELW(SELW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt(gnt),
        .eng_sel(eng_sel),
        .eng_en(eng_en),
        .eng_mv(eng_mv),
        .res_data(res_data),
        .res_id(res_id),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .busy(busy),
        .jobs_done(jobs_done)
    );

    // Element i of requester k's result is i + 16*k; k=0 gives 0x0F0E..0100.
    function automatic logic [DW-1:0] pat(input int k);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < DIMENSION; i++)
            v[i*WIDTH +: WIDTH] = WIDTH'(i + 16 * k);
        return v;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int k);
        logic [NREQ-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Engine model: result only meaningful once the run has finished.
    always_comb begin
        if (eng_en) eng_mv = {DIMENSION{8'hA5}};
        else        eng_mv = pat(int'(eng_sel));
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Precondition: at a negedge in IDLE with req driven. Ends at the first RESP negedge.
    task automatic do_job(input int k, input logic [NREQ-1:0] req_after);
        int bad;
        step();
        chk("grant_gnt", DW'(gnt), DW'(onehot(k)));
        chk("grant_sel", DW'(eng_sel), DW'(k));
        chk("grant_en", DW'(eng_en), DW'(1));
        chk("grant_busy", DW'(busy), DW'(1));
        req = req_after;
        bad = 0;
        repeat (31) begin
            step();
            if (eng_en !== 1'b1 || gnt !== onehot(k) || eng_sel !== SELW'(k)) bad++;
        end
        chk("run_len", DW'(bad), DW'(0));
        step();
        chk("capture_en", DW'(eng_en), DW'(0));
        chk("capture_valid", DW'(res_valid), DW'(0));
        step();
        chk("resp_valid", DW'(res_valid), DW'(1));
        chk("resp_id", DW'(res_id), DW'(k));
        chk("resp_data", res_data, pat(k));
        chk("resp_en", DW'(eng_en), DW'(0));
        chk("resp_gnt", DW'(gnt), DW'(onehot(k)));
    endtask

    // Handshake edge with res_ready already high; ends in IDLE.
    task automatic hs();
        step();
        exp_jobs = exp_jobs + 16'd1;
        chk("hs_jobs", DW'(jobs_done), DW'(exp_jobs));
        chk("hs_valid", DW'(res_valid), DW'(0));
        chk("hs_gnt", DW'(gnt), DW'(0));
        chk("hs_en", DW'(eng_en), DW'(0));
        chk("hs_busy", DW'(busy), DW'(0));
    endtask

    initial begin
        int bad;
        rst       = 1'b1;
        req       = '0;
        res_ready = 1'b0;
        step();
        step();
        chk("rst_gnt", DW'(gnt), DW'(0));
        chk("rst_sel", DW'(eng_sel), DW'(0));
        chk("rst_en", DW'(eng_en), DW'(0));
        chk("rst_data", res_data, '0);
        chk("rst_id", DW'(res_id), DW'(0));
        chk("rst_valid", DW'(res_valid), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_jobs", DW'(jobs_done), DW'(0));
        rst = 1'b0;

        // Single job; req dropped after grant must not cancel it.
        res_ready = 1'b1;
        req = 4'b0001;
        do_job(0, 4'b0000);
        chk("single_jobs_before_hs", DW'(jobs_done), DW'(0));
        hs();

        // Mid-run reset, starting from a fresh reset so jobs_done is 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_jobs = '0;
        req = 4'b0100;
        step();
        chk("abort_grant", DW'(gnt), DW'(4'b0100));
        req = 4'b0000;
        repeat (10) step();
        rst = 1'b1;
        step();
        chk("abort_en", DW'(eng_en), DW'(0));
        chk("abort_gnt", DW'(gnt), DW'(0));
        chk("abort_busy", DW'(busy), DW'(0));
        chk("abort_valid", DW'(res_valid), DW'(0));
        chk("abort_jobs", DW'(jobs_done), DW'(0));
        rst = 1'b0;

        // Round-robin from pointer 0 with all requesters active.
        req = 4'b1111;
        do_job(0, 4'b1111); hs();
        do_job(1, 4'b1111); hs();
        do_job(2, 4'b1111); hs();
        do_job(3, 4'b1111); hs();
        do_job(0, 4'b1111); hs();

        // Backpressure: pointer is 1, only requester 0 asks.
        req = 4'b0001;
        res_ready = 1'b0;
        do_job(0, 4'b1110);
        bad = 0;
        repeat (10) begin
            step();
            if (res_valid !== 1'b1 || res_data !== pat(0) || res_id !== 2'd0 ||
                eng_en !== 1'b0 || gnt !== 4'b0001 || busy !== 1'b1) bad++;
        end
        chk("bp_hold", DW'(bad), DW'(0));
        res_ready = 1'b1;
        hs();
        do_job(1, 4'b0000); hs();

        // Pointer wrap.
        req = 4'b1000;
        do_job(3, 4'b0000); hs();
        req = 4'b1001;
        do_job(0, 4'b1001); hs();
        do_job(3, 4'b0000); hs();

        // jobs_done wrap via forced preload while waiting in RESP.
        req = 4'b0010;
        res_ready = 1'b0;
        do_job(1, 4'b0000);
        force dut.jobs_done = 16'hFFFF;
        step();
        release dut.jobs_done;
        exp_jobs = 16'hFFFF;
        res_ready = 1'b1;
        hs();
        chk("wrap_zero", DW'(jobs_done), DW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
